// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Purpose: UART transmitter on the core's data-memory port. Stores push bytes
// into a circular FIFO. A four-state FSM serialises them 8N1, LSB first.
// Loads return data combinationally in the same cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mem_ena    one-cycle access strobe
//   mem_rw     0 = read, 1 = write
//   mem_addr   byte address (window match on [31:4], register on [3:2])
//   mem_wdata  store data
//   mem_rdata  load data, combinational; 0 outside the window or on writes
//   sel_o      combinational window hit, used upstream to mux against RAM
//   uart_tx    serial line, idle high, registered
//   irq_o      registered: FIFO empty and transmitter idle

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ena,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        sel_o,
  output logic        uart_tx,
  output logic        irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          overflow;
  logic [15:0]   div;
  logic [15:0]   period;
  logic [15:0]   timer;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          tx_q;
  logic          irq_q;

  logic [1:0]    off;
  logic          wr;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;
  logic          busy;
  logic          unused;

  assign sel_o    = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign off      = mem_addr[3:2];
  assign wr       = mem_ena & mem_rw & sel_o;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = wr && (off == 2'd0);
  // Full is judged on the pre-pop count, so a push into a full FIFO is lost
  // even when the transmitter pops on the same edge.
  assign push_ok  = push_req && !full;
  assign pop      = (state == IDLE) && !empty;
  assign uart_tx  = tx_q;
  assign irq_o    = irq_q;
  assign unused   = ^{mem_wdata[31:16], mem_addr[1:0]};

  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + CW'(1);
    end else if (!push_ok && pop) begin
      count_next = count - CW'(1);
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (sel_o && !mem_rw) begin
      case (off)
        2'd1:    mem_rdata = {28'b0, overflow, empty, full, busy};
        2'd2:    mem_rdata = {16'b0, div};
        default: mem_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DIV_RESET;
    end else begin
      count <= count_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr && (off == 2'd1) && mem_wdata[3]) begin
        overflow <= 1'b0;
      end else if (push_req && full) begin
        overflow <= 1'b1;
      end
      if (wr && (off == 2'd2)) begin
        // A zero divisor would stall the bit timer, so it is held at 1.
        div <= (mem_wdata[15:0] == 16'd0) ? 16'd1 : mem_wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      period  <= DIV_RESET;
      timer   <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            // The divisor is captured per frame so mid-frame DIV writes
            // only affect the next frame.
            shift  <= fifo_mem[rd_ptr];
            period <= div;
            timer  <= div - 16'd1;
            state  <= START;
            tx_q   <= 1'b0;
            irq_q  <= 1'b0;
          end else begin
            irq_q <= (count_next == '0);
          end
        end
        START: begin
          if (timer == 16'd0) begin
            state   <= DATA;
            timer   <= period - 16'd1;
            bit_cnt <= 3'd0;
            tx_q    <= shift[0];
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (timer == 16'd0) begin
            timer <= period - 16'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        STOP: begin
          if (timer == 16'd0) begin
            // Always pass through IDLE for one cycle before the next start bit.
            state <= IDLE;
            irq_q <= (count_next == '0);
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        mem_ena;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        sel_o;
  logic        uart_tx;
  logic        irq_o;

  int vectors;
  int miscompares;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (16'd434)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_ena  (mem_ena),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .sel_o    (sel_o),
    .uart_tx  (uart_tx),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus a description of the frame in
  // flight (byte, divisor, cycles elapsed). Line level follows from the
  // position within the 10-bit frame.
  logic [7:0]  model_q[$];
  logic        m_active;
  int          m_pos;
  int          m_fdiv;
  logic [7:0]  m_byte;
  int          m_div;
  logic        m_ovf;
  int          m_old_size;
  int          m_k;
  logic        m_tx;
  logic [31:0] m_rdata;
  logic        m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_fdiv   = 1;
      m_byte   = 8'h00;
      m_div    = 434;
      m_ovf    = 1'b0;
    end else begin
      m_old_size = model_q.size();
      if (m_active) begin
        if (m_pos + 1 < 10 * m_fdiv) m_pos = m_pos + 1;
        else m_active = 1'b0;
      end else if (m_old_size > 0) begin
        m_byte   = model_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
        m_fdiv   = m_div;
      end
      if (mem_ena && mem_rw && ((mem_addr >> 4) == (BASE >> 4))) begin
        case (mem_addr[3:2])
          2'd0: if (m_old_size == DEPTH) m_ovf = 1'b1; else model_q.push_back(mem_wdata[7:0]);
          2'd1: if (mem_wdata[3]) m_ovf = 1'b0;
          2'd2: m_div = (mem_wdata[15:0] == 16'd0) ? 1 : int'(mem_wdata[15:0]);
          default: ;
        endcase
      end
    end
    #1;
    if (!m_active) m_tx = 1'b1;
    else begin
      m_k = m_pos / m_fdiv;
      if (m_k == 0) m_tx = 1'b0;
      else if (m_k <= 8) m_tx = m_byte[m_k-1];
      else m_tx = 1'b1;
    end
    m_sel   = ((mem_addr >> 4) == (BASE >> 4));
    m_rdata = 32'd0;
    if (m_sel && !mem_rw) begin
      if (mem_addr[3:2] == 2'd1)
        m_rdata = {28'd0, m_ovf, (model_q.size() == 0), (model_q.size() == DEPTH), m_active};
      else if (mem_addr[3:2] == 2'd2)
        m_rdata = m_div;
    end
    check("model_tx", {31'd0, uart_tx}, {31'd0, m_tx});
    check("model_irq", {31'd0, irq_o}, {31'd0, (!m_active && model_q.size() == 0)});
    check("model_sel", {31'd0, sel_o}, {31'd0, m_sel});
    check("model_rdata", mem_rdata, m_rdata);
  end

  // Called at a falling edge; the store lands on the next rising edge and the
  // task returns on the following falling edge with the bus parked on STATUS.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_ena   = 1'b1;
    mem_rw    = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    @(negedge clk);
    mem_ena   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = BASE + 32'h4;
    mem_wdata = 32'd0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    #1;
    check(name, mem_rdata, exp);
    mem_addr = BASE + 32'h4;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (!irq_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!irq_o) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [9:0] f55;
  logic [9:0] fa5;
  logic [9:0] f3c;
  int         n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    rst         = 1'b0;
    mem_ena     = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = BASE + 32'h4;
    mem_wdata   = 32'd0;
    f55 = 10'b1010101010;
    fa5 = 10'b1101001010;
    f3c = 10'b1001111000;

    // Reset values before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_irq", {31'd0, irq_o}, 32'd1);
    read_check("rst_status", BASE + 32'h4, 32'h4);
    read_check("rst_div", BASE + 32'h8, 32'd434);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x55 at div 4.
    bus_write(BASE + 32'h8, 32'd4);
    bus_write(BASE + 32'h0, 32'h55);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      check("b55_tx", {31'd0, uart_tx}, {31'd0, f55[i/4]});
      check("b55_busy", {31'd0, mem_rdata[0]}, 32'd1);
      @(negedge clk);
    end
    check("b55_irq_done", {31'd0, irq_o}, 32'd1);
    check("b55_status_done", mem_rdata, 32'h4);

    // Back-to-back 0xA5, 0x3C at div 2 with a single idle cycle between frames.
    bus_write(BASE + 32'h8, 32'd2);
    bus_write(BASE + 32'h0, 32'hA5);
    bus_write(BASE + 32'h0, 32'h3C);
    for (int i = 0; i < 41; i++) begin
      if (i < 20) check("b2b_a5", {31'd0, uart_tx}, {31'd0, fa5[i/2]});
      else if (i == 20) check("b2b_gap", {31'd0, uart_tx}, 32'd1);
      else check("b2b_3c", {31'd0, uart_tx}, {31'd0, f3c[(i-21)/2]});
      @(negedge clk);
    end
    check("b2b_irq", {31'd0, irq_o}, 32'd1);

    // Overflow with ten pushes at div 100.
    bus_write(BASE + 32'h8, 32'd100);
    for (int i = 0; i < 10; i++) bus_write(BASE + 32'h0, 32'(i + 1));
    read_check("ovf_status", BASE + 32'h4, 32'hB);
    bus_write(BASE + 32'h4, 32'h8);
    read_check("ovf_cleared", BASE + 32'h4, 32'h3);
    pulse_reset();

    // Divisor 0 is stored as 1: 10-cycle frame, irq returns 11 cycles after push.
    bus_write(BASE + 32'h8, 32'd0);
    read_check("div0_read", BASE + 32'h8, 32'd1);
    bus_write(BASE + 32'h0, 32'h0F);
    wait_idle(200, n);
    check("div1_frame_cycles", 32'(n), 32'd11);
    @(negedge clk);

    // Divisor change mid-frame: 30-cycle frame then 80-cycle frame.
    bus_write(BASE + 32'h8, 32'd3);
    bus_write(BASE + 32'h0, 32'h81);
    bus_write(BASE + 32'h0, 32'h7E);
    repeat (5) @(negedge clk);
    bus_write(BASE + 32'h8, 32'd8);
    wait_idle(300, n);
    check("divchg_total", 32'(n), 32'd105);
    read_check("divchg_read", BASE + 32'h8, 32'd8);
    @(negedge clk);

    // Asynchronous reset in the middle of the data bits.
    bus_write(BASE + 32'h8, 32'd4);
    bus_write(BASE + 32'h0, 32'h00);
    repeat (10) @(negedge clk);
    check("arst_pre_low", {31'd0, uart_tx}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_tx", {31'd0, uart_tx}, 32'd1);
    check("arst_irq", {31'd0, irq_o}, 32'd1);
    read_check("arst_status", BASE + 32'h4, 32'h4);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      check("arst_no_frame", {31'd0, uart_tx}, 32'd1);
      @(negedge clk);
    end

    // Access outside the register window.
    mem_addr = 32'h0000_2000;
    #1;
    check("nowin_sel", {31'd0, sel_o}, 32'd0);
    check("nowin_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    bus_write(32'h0000_2000, 32'h41);
    bus_write(32'h0000_2008, 32'd7);
    repeat (3) @(negedge clk);
    check("nowin_irq", {31'd0, irq_o}, 32'd1);
    read_check("nowin_status", BASE + 32'h4, 32'h4);
    read_check("nowin_div", BASE + 32'h8, 32'd434);
    read_check("reg_c_zero", BASE + 32'hC, 32'd0);
    read_check("txdata_zero", BASE + 32'h0, 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
